// File: rtl/serial_digit_adder.sv
// Digit-serial adder: DIGIT bits per cycle, LSB digit first, registered inter-digit carry.
// Optional subtract mode enabled by defining SERIAL_DIGIT_ADDER_SUB_EN (adds a `sub` port).
module serial_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Operand conditioning at capture: subtract folds into a + ~b + 1.
  always_comb begin
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
`else
    b_in = b;
    c_in = cin;
`endif
  end

  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sr[i] ^ b_sr[i] ^ c[i];
      c[i+1]   = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
    end
  end

  // Result digits enter at the MSB end so after N shifts digit 0 sits at the LSB.
  always_comb begin
    sum_sh = sum >> DIGIT;
    sum_sh[WIDTH-1 -: DIGIT] = dsum;
    a_sh = a_sr >> DIGIT;
    b_sh = b_sr >> DIGIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_in;
            carry <= c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= sum_sh;
          a_sr  <= a_sh;
          b_sr  <= b_sh;
          carry <= c[DIGIT];
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            cout     <= c[DIGIT];
            overflow <= c[DIGIT] ^ c[DIGIT-1];
            busy     <= 1'b0;
            done     <= 1'b1;
            idx      <= '0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder (WIDTH=8, DIGIT=2) plus a strided sweep over DIGIT=1,2,4,8.
module tb_serial_digit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst, start, cin, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ov;
  logic [7:0] sum;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(ov)
  );

  logic       s_start, s_cin, s_sub;
  logic [7:0] s_a, s_b;
  logic [3:0] s_busy, s_done, s_cout, s_ov;
  logic [7:0] s_sum [4];

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy[0]), .done(s_done[0]), .sum(s_sum[0]), .cout(s_cout[0]), .overflow(s_ov[0]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy[1]), .done(s_done[1]), .sum(s_sum[1]), .cout(s_cout[1]), .overflow(s_ov[1]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy[2]), .done(s_done[2]), .sum(s_sum[2]), .cout(s_cout[2]), .overflow(s_ov[2]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy[3]), .done(s_done[3]), .sum(s_sum[3]), .cout(s_cout[3]), .overflow(s_ov[3]));

  // Stimulus only: presents one operation, returns what the DUT produced.
  // lat counts cycles from the start cycle to the done cycle (-1 on timeout).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output logic [7:0] rs, output logic rco, output logic rov,
                        output int lat, output int bcnt);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0; rs = 'x; rco = 1'bx; rov = 1'bx;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      if (busy) bcnt++;
      if (done) begin
        rs = sum; rco = cout; rov = ov; lat = j + 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ov} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ov=%b, want all zero",
               busy, done, sum, cout, ov);
    end
  endtask

  task automatic test_basic();
    logic [7:0] rs; logic rco, rov; int lat, bcnt;
    run_op(8'h3C, 8'h05, 1'b0, rs, rco, rov, lat, bcnt);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++;
    if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
    checks++;
    if ({rs, rco, rov} !== {8'h41, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result: sum=%h cout=%b ov=%b want 41/0/0", rs, rco, rov);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, sum} !== {1'b0, 1'b0, 8'h41}) begin
      errors++; $display("FAIL basic_done_pulse_hold: done=%b busy=%b sum=%h want 0/0/41", done, busy, sum);
    end
  endtask

  task automatic test_carry_overflow();
    logic [7:0] rs; logic rco, rov; int lat, bcnt;
    run_op(8'hFF, 8'h01, 1'b0, rs, rco, rov, lat, bcnt);
    checks++;
    if ({rs, rco, rov} !== {8'h00, 1'b1, 1'b0} || lat !== 5) begin
      errors++; $display("FAIL carry_wrap: sum=%h cout=%b ov=%b lat=%0d want 00/1/0 lat 5", rs, rco, rov, lat);
    end
    run_op(8'h7F, 8'h00, 1'b1, rs, rco, rov, lat, bcnt);
    checks++;
    if ({rs, rco, rov} !== {8'h80, 1'b0, 1'b1} || lat !== 5) begin
      errors++; $display("FAIL signed_overflow: sum=%h cout=%b ov=%b lat=%0d want 80/0/1 lat 5", rs, rco, rov, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] rs; logic rco, rov;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    // start stays high with junk operands during RUN: must be ignored
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    lat = -1;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      if (done) begin rs = sum; rco = cout; rov = ov; lat = j + 1; end
      else @(negedge clk);
    end
    checks++;
    if ({rs, rco, rov} !== {8'h00, 1'b1, 1'b1} || lat !== 5) begin
      errors++; $display("FAIL b2b_first: sum=%h cout=%b ov=%b lat=%0d want 00/1/1 lat 5", rs, rco, rov, lat);
    end
    a = 8'h01; b = 8'h02; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", busy, done);
    end
    lat = -1;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      if (done) begin rs = sum; rco = cout; rov = ov; lat = j + 1; end
      else @(negedge clk);
    end
    checks++;
    if ({rs, rco, rov} !== {8'h03, 1'b0, 1'b0} || lat !== 5) begin
      errors++; $display("FAIL b2b_second: sum=%h cout=%b ov=%b gap=%0d want 03/0/0 gap 5", rs, rco, rov, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [7:0] rs; logic rco, rov; int lat, bcnt, pulses;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, cout, ov} !== 12'h000) begin
      errors++; $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b ov=%b want all zero",
                         busy, done, sum, cout, ov);
    end
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: activity cycles=%0d want 0", pulses); end
    run_op(8'h10, 8'h20, 1'b0, rs, rco, rov, lat, bcnt);
    checks++;
    if ({rs, rco, rov} !== {8'h30, 1'b0, 1'b0} || lat !== 5) begin
      errors++; $display("FAIL abort_recover: sum=%h cout=%b ov=%b lat=%0d want 30/0/0 lat 5", rs, rco, rov, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] blist [8];
    logic [8:0] full, low;
    logic       ref_ov;
    logic [3:0] got;
    logic [7:0] rs [4];
    logic [3:0] rc, rv;
    blist[0] = 8'h00; blist[1] = 8'h01; blist[2] = 8'h7F; blist[3] = 8'h80;
    blist[4] = 8'hFF; blist[5] = 8'h55; blist[6] = 8'hAA; blist[7] = 8'h3C;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        s_a = 8'(ai); s_b = blist[bi]; s_cin = s_a[0] ^ s_b[1];
        full   = {1'b0, s_a} + {1'b0, s_b} + {8'h00, s_cin};
        low    = {2'b00, s_a[6:0]} + {2'b00, s_b[6:0]} + {8'h00, s_cin};
        ref_ov = low[7] ^ full[8];
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        got = '0;
        for (int j = 0; j < 14 && got != 4'hF; j++) begin
          for (int k = 0; k < 4; k++) begin
            if (s_done[k] && !got[k]) begin
              got[k] = 1'b1; rs[k] = s_sum[k]; rc[k] = s_cout[k]; rv[k] = s_ov[k];
            end
          end
          if (got != 4'hF) @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (!got[k] || {rs[k], rc[k], rv[k]} !== {full[7:0], full[8], ref_ov}) begin
            errors++;
            $display("FAIL sweep_digit%0d: a=%h b=%h cin=%b got sum=%h cout=%b ov=%b done=%b want %h/%b/%b",
                     1 << k, s_a, s_b, s_cin, rs[k], rc[k], rv[k], got[k], full[7:0], full[8], ref_ov);
          end
        end
      end
    end
  endtask

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] rs; logic rco, rov; int lat, bcnt;
    sub = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, rs, rco, rov, lat, bcnt);
    checks++;
    if ({rs, rco, rov} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: sum=%h cout=%b ov=%b want FE/0/0", rs, rco, rov);
    end
    run_op(8'h80, 8'h01, 1'b1, rs, rco, rov, lat, bcnt);
    checks++;
    if ({rs, rco, rov} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_overflow: sum=%h cout=%b ov=%b want 7F/1/1", rs, rco, rov);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_overflow();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    test_sub();
`endif
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
